// File: rtl/uart_debug_cmd.sv
// Byte-level debug command engine: parses 'W'/'R' frames from the UART receiver,
// issues one register-bus access and returns 'K', read data (MSB first) or 'E'.
module uart_debug_cmd #(
  parameter int unsigned RX_TIMEOUT = 2500000,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_overflow,
  input  logic        rx_parity_error,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_busy,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [31:0] reg_rdata,
  input  logic        reg_rdata_valid,
  output logic [31:0] debug_bus_c
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_GET_ADDR  = 4'd1;
  localparam logic [3:0] S_GET_DATA  = 4'd2;
  localparam logic [3:0] S_EXEC_WR   = 4'd3;
  localparam logic [3:0] S_EXEC_RD   = 4'd4;
  localparam logic [3:0] S_WAIT_RD   = 4'd5;
  localparam logic [3:0] S_SEND      = 4'd6;
  localparam logic [3:0] S_SEND_WAIT = 4'd7;

  localparam logic [31:0] RX_LAST = 32'(RX_TIMEOUT - 1);
  localparam logic [7:0]  RD_LIM  = 8'(RD_TIMEOUT);

  logic [3:0]  state;
  logic [7:0]  err_count;
  logic [7:0]  last_opcode;
  logic [2:0]  byte_cnt;
  logic [31:0] rx_timer;
  logic [7:0]  rd_timer;
  logic [31:0] resp;
  logic [2:0]  resp_cnt;
  logic        seen_busy;
  logic        is_wr;

  logic in_rx, frame_err, rx_ok, bad_op, rd_to, rx_to, load_e;

  assign in_rx     = (state == S_IDLE) || (state == S_GET_ADDR) || (state == S_GET_DATA);
  assign frame_err = (rx_valid && rx_parity_error) || rx_overflow;
  assign rx_ok     = rx_valid && !frame_err;
  assign bad_op    = (state == S_IDLE) && rx_ok && (rx_data != 8'h57) && (rx_data != 8'h52);
  // Returned data takes priority over a coincident read timeout
  assign rd_to     = (state == S_WAIT_RD) && !reg_rdata_valid && (rd_timer >= RD_LIM);
  assign rx_to     = ((state == S_GET_ADDR) || (state == S_GET_DATA)) && !rx_valid &&
                     !rx_overflow && (rx_timer >= RX_LAST);
  assign load_e    = (in_rx && frame_err) || bad_op || rd_to;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state       <= S_IDLE;
      err_count   <= 8'd0;
      last_opcode <= 8'd0;
      byte_cnt    <= 3'd0;
      rx_timer    <= 32'd0;
      rd_timer    <= 8'd0;
      resp        <= 32'd0;
      resp_cnt    <= 3'd0;
      seen_busy   <= 1'b0;
      is_wr       <= 1'b0;
      tx_data     <= 8'd0;
      tx_valid    <= 1'b0;
      reg_addr    <= 8'd0;
      reg_wdata   <= 32'd0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      debug_bus_c <= 32'd0;
    end else begin
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      tx_valid <= 1'b0;
      // Top pad is 5 bits so the listed fields fit in 32
      debug_bus_c <= {5'd0, err_count, last_opcode, byte_cnt, tx_valid, reg_wr, reg_rd,
                      rx_valid, state};
      case (state)
        S_IDLE: begin
          rx_timer <= 32'd0;
          if (rx_valid) last_opcode <= rx_data;
          if (rx_ok && (rx_data == 8'h57 || rx_data == 8'h52)) begin
            is_wr <= (rx_data == 8'h57);
            state <= S_GET_ADDR;
          end
        end
        S_GET_ADDR: begin
          rx_timer <= rx_valid ? 32'd0 : rx_timer + 32'd1;
          if (rx_ok) begin
            reg_addr <= rx_data;
            byte_cnt <= 3'd0;
            state    <= is_wr ? S_GET_DATA : S_EXEC_RD;
          end
        end
        S_GET_DATA: begin
          rx_timer <= rx_valid ? 32'd0 : rx_timer + 32'd1;
          if (rx_ok) begin
            reg_wdata <= {reg_wdata[23:0], rx_data};
            byte_cnt  <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd3) state <= S_EXEC_WR;
          end
        end
        S_EXEC_WR: begin
          reg_wr   <= 1'b1;
          resp     <= {8'h4B, 24'd0};
          resp_cnt <= 3'd1;
          state    <= S_SEND;
        end
        S_EXEC_RD: begin
          reg_rd   <= 1'b1;
          rd_timer <= 8'd0;
          state    <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          if (reg_rdata_valid) begin
            resp     <= reg_rdata;
            resp_cnt <= 3'd4;
            state    <= S_SEND;
          end else begin
            rd_timer <= rd_timer + 8'd1;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_data   <= resp[31:24];
            tx_valid  <= 1'b1;
            seen_busy <= 1'b0;
            state     <= S_SEND_WAIT;
          end
        end
        S_SEND_WAIT: begin
          // A byte is done only once busy has risen and fallen again
          if (tx_busy) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            resp     <= {resp[23:0], 8'd0};
            resp_cnt <= resp_cnt - 3'd1;
            state    <= (resp_cnt == 3'd1) ? S_IDLE : S_SEND;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (rx_to) state <= S_IDLE;
      if (load_e) begin
        resp     <= {8'h45, 24'd0};
        resp_cnt <= 3'd1;
        state    <= S_SEND;
      end
      if ((load_e || rx_to) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_debug_cmd.sv
// Self-checking bench for uart_debug_cmd: UART/bus models plus a frame-level reference
// model (expected responses, writes and error counts derived from the command rules).
module tb_uart_debug_cmd;
  localparam int RXT = 100;
  localparam int RDT = 10;

  logic        core_clk = 1'b0;
  logic        core_rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_overflow, rx_parity_error;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy = 1'b0;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr, reg_rd;
  logic [31:0] reg_rdata = 32'd0;
  logic        reg_rdata_valid = 1'b0;
  logic [31:0] debug_bus_c;

  uart_debug_cmd #(.RX_TIMEOUT(RXT), .RD_TIMEOUT(RDT)) dut (
    .core_clk(core_clk), .core_rst(core_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_overflow(rx_overflow), .rx_parity_error(rx_parity_error), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_busy(tx_busy), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .reg_rdata_valid(reg_rdata_valid), .debug_bus_c(debug_bus_c));

  always #5 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  int nvec = 0, nfail = 0;
  logic [7:0]  tx_q[$];
  logic [39:0] wr_q[$];
  logic [31:0] bus_mem [logic [7:0]];
  logic [31:0] ref_mem [logic [7:0]];
  int rd_cnt = 0, viol = 0, busy_cnt = 0, busy_len = 0, rd_delay = 3, rd_pend = 0;
  int wr_cyc = 0, rd_cyc = 0, tx_cyc = 0, last_rx_cyc = 0, err_exp = 0;
  bit seen_hi = 1'b1;
  logic [7:0] rd_addr = 8'd0;

  function automatic logic [31:0] dflt(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, a + 8'd1};
  endfunction

  // UART transmitter and register-bus models, sampled mid-cycle
  always @(negedge core_clk) begin
    if (core_rst) begin
      busy_cnt = 0; tx_busy = 1'b0; rd_pend = 0; reg_rdata_valid = 1'b0; seen_hi = 1'b1;
    end else begin
      if (tx_valid) begin
        if (tx_busy || !seen_hi) viol++;
        tx_q.push_back(tx_data);
        tx_cyc = cyc;
        seen_hi = 1'b0;
        busy_cnt = (busy_len != 0) ? busy_len : $urandom_range(2, 5);
        tx_busy = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        tx_busy = (busy_cnt != 0);
      end
      if (tx_busy) seen_hi = 1'b1;
      reg_rdata_valid = 1'b0;
      if (rd_pend > 0) begin
        rd_pend--;
        if (rd_pend == 0) begin
          reg_rdata_valid = 1'b1;
          reg_rdata = bus_mem.exists(rd_addr) ? bus_mem[rd_addr] : dflt(rd_addr);
        end
      end
      if (reg_rd) begin rd_cnt++; rd_cyc = cyc; rd_pend = rd_delay; rd_addr = reg_addr; end
      if (reg_wr) begin
        wr_q.push_back({reg_addr, reg_wdata});
        bus_mem[reg_addr] = reg_wdata;
        wr_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic par);
    @(negedge core_clk);
    rx_data = b; rx_valid = 1'b1; rx_parity_error = par; last_rx_cyc = cyc;
    @(negedge core_clk);
    rx_valid = 1'b0; rx_parity_error = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fr[$]);
    foreach (fr[i]) begin
      send_byte(fr[i], 1'b0);
      repeat ($urandom_range(0, 4)) @(negedge core_clk);
    end
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_q.size() < n && k < 400) begin @(negedge core_clk); k++; end
    repeat (30) @(negedge core_clk);
  endtask

  task automatic clear_obs();
    tx_q.delete(); wr_q.delete(); rd_cnt = 0;
  endtask

  function automatic void bump_err();
    if (err_exp < 255) err_exp++;
  endfunction

  task automatic test_reset();
    core_rst = 1'b1;
    repeat (3) @(negedge core_clk);
    nvec++;
    if ({tx_data, tx_valid, reg_addr, reg_wdata, reg_wr, reg_rd} !== 50'd0) begin
      nfail++; $display("FAIL reset_outputs: got %h required 0",
                        {tx_data, tx_valid, reg_addr, reg_wdata, reg_wr, reg_rd});
    end
    nvec++;
    if (debug_bus_c !== 32'd0) begin
      nfail++; $display("FAIL reset_debug: got %h required 0", debug_bus_c);
    end
    core_rst = 1'b0;
    repeat (2) @(negedge core_clk);
  endtask

  task automatic test_bad_opcode();
    clear_obs();
    send_byte(8'h41, 1'b0);
    bump_err();
    wait_tx(1);
    nvec++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h45) begin
      nfail++; $display("FAIL bad_op_resp: got %0d bytes first %h required 1 byte 45",
                        tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00);
    end
    nvec++;
    if (wr_q.size() + rd_cnt !== 0) begin
      nfail++; $display("FAIL bad_op_strobe: got %0d strobes required 0", wr_q.size() + rd_cnt);
    end
    nvec++;
    if (debug_bus_c[26:19] !== 8'd1) begin
      nfail++; $display("FAIL bad_op_errcnt: got %0d required 1", debug_bus_c[26:19]);
    end
  endtask

  task automatic test_write();
    clear_obs();
    send_frame('{8'h57, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    ref_mem[8'h10] = 32'hDEADBEEF;
    wait_tx(1);
    nvec++;
    if (wr_q.size() !== 1 || wr_q[0] !== 40'h10DEADBEEF) begin
      nfail++; $display("FAIL write_access: got %0d writes first %h required 1 of 10deadbeef",
                        wr_q.size(), wr_q.size() ? wr_q[0] : 40'h0);
    end
    nvec++;
    if (wr_cyc !== last_rx_cyc + 2) begin
      nfail++; $display("FAIL write_latency: got %0d required %0d", wr_cyc - last_rx_cyc, 2);
    end
    nvec++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
      nfail++; $display("FAIL write_ack: got %0d bytes first %h required 1 byte 4b",
                        tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00);
    end
  endtask

  task automatic test_read();
    logic [7:0] exp[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    clear_obs();
    bus_mem[8'h20] = 32'h12345678;
    ref_mem[8'h20] = 32'h12345678;
    rd_delay = 3;
    send_frame('{8'h52, 8'h20});
    wait_tx(4);
    nvec++;
    if (rd_cyc !== last_rx_cyc + 2 || rd_cnt !== 1) begin
      nfail++; $display("FAIL read_latency: got %0d (%0d reads) required 2 (1 read)",
                        rd_cyc - last_rx_cyc, rd_cnt);
    end
    nvec++;
    if (tx_q.size() !== 4) begin
      nfail++; $display("FAIL read_len: got %0d required 4", tx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (tx_q[i] !== exp[i]) begin
          nfail++; $display("FAIL read_byte%0d: got %h required %h", i, tx_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_parity();
    clear_obs();
    send_byte(8'h57, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h11, 1'b1);
    bump_err();
    wait_tx(1);
    nvec++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h45 || wr_q.size() !== 0) begin
      nfail++; $display("FAIL parity_abort: got %0d bytes first %h, %0d writes required 1 byte 45, 0 writes",
                        tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00, wr_q.size());
    end
    nvec++;
    if (reg_wdata !== 32'hDEADBEEF) begin
      nfail++; $display("FAIL parity_hold_wdata: got %h required deadbeef", reg_wdata);
    end
  endtask

  task automatic test_rx_timeout();
    clear_obs();
    send_frame('{8'h57, 8'h10, 8'h01});
    repeat (RXT - 10) @(negedge core_clk);
    nvec++;
    if (debug_bus_c[26:19] !== 8'(err_exp)) begin
      nfail++; $display("FAIL rx_timeout_early: got errcnt %0d required %0d", debug_bus_c[26:19], err_exp);
    end
    repeat (40) @(negedge core_clk);
    bump_err();
    nvec++;
    if (debug_bus_c[26:19] !== 8'(err_exp) || tx_q.size() !== 0 || wr_q.size() !== 0) begin
      nfail++; $display("FAIL rx_timeout: got errcnt %0d tx %0d wr %0d required %0d 0 0",
                        debug_bus_c[26:19], tx_q.size(), wr_q.size(), err_exp);
    end
    nvec++;
    if (reg_wdata !== 32'hADBEEF01) begin
      nfail++; $display("FAIL rx_timeout_wdata: got %h required adbeef01", reg_wdata);
    end
  endtask

  task automatic test_rd_timeout();
    clear_obs();
    rd_delay = 0;
    send_frame('{8'h52, 8'h33});
    bump_err();
    wait_tx(1);
    rd_delay = 3;
    nvec++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h45 || rd_cnt !== 1) begin
      nfail++; $display("FAIL rd_timeout_resp: got %0d bytes first %h reads %0d required 1 byte 45, 1 read",
                        tx_q.size(), tx_q.size() ? tx_q[0] : 8'h00, rd_cnt);
    end
    nvec++;
    if (tx_cyc - rd_cyc < RDT || tx_cyc - rd_cyc > RDT + 4) begin
      nfail++; $display("FAIL rd_timeout_delay: got %0d cycles required %0d..%0d",
                        tx_cyc - rd_cyc, RDT, RDT + 4);
    end
  endtask

  task automatic test_drop_in_send();
    clear_obs();
    busy_len = 12;
    send_byte(8'h41, 1'b0);
    bump_err();
    repeat (3) @(negedge core_clk);
    send_byte(8'h52, 1'b0);
    send_byte(8'h20, 1'b0);
    wait_tx(1);
    busy_len = 0;
    nvec++;
    if (tx_q.size() !== 1 || rd_cnt !== 0) begin
      nfail++; $display("FAIL drop_in_send: got %0d bytes %0d reads required 1 byte 0 reads",
                        tx_q.size(), rd_cnt);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [7:0]  fr[$];
      logic [7:0]  exp[$];
      logic [7:0]  a;
      logic [31:0] d;
      int kind;
      clear_obs();
      kind = $urandom_range(0, 2);
      a = 8'($urandom);
      d = $urandom;
      rd_delay = $urandom_range(1, 8);
      if (kind == 0) begin
        fr = '{8'h57, a, d[31:24], d[23:16], d[15:8], d[7:0]};
        exp = '{8'h4B};
        ref_mem[a] = d;
      end else if (kind == 1) begin
        fr = '{8'h52, a};
        d = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        exp = '{d[31:24], d[23:16], d[15:8], d[7:0]};
      end else begin
        a = 8'($urandom_range(0, 255));
        if (a == 8'h57 || a == 8'h52) a = 8'h00;
        fr = '{a};
        exp = '{8'h45};
        bump_err();
      end
      send_frame(fr);
      wait_tx(exp.size());
      nvec++;
      if (tx_q !== exp) begin
        nfail++; $display("FAIL rand%0d_resp: got %p required %p", it, tx_q, exp);
      end
      nvec++;
      if (kind == 0 ? (wr_q.size() !== 1 || wr_q[0] !== {a, d} || rd_cnt !== 0)
                    : (wr_q.size() !== 0 || rd_cnt !== (kind == 1 ? 1 : 0))) begin
        nfail++; $display("FAIL rand%0d_bus: got %0d writes %0d reads (kind %0d)",
                          it, wr_q.size(), rd_cnt, kind);
      end
    end
    nvec++;
    if (debug_bus_c[26:19] !== 8'(err_exp)) begin
      nfail++; $display("FAIL rand_errcnt: got %0d required %0d", debug_bus_c[26:19], err_exp);
    end
    nvec++;
    if (viol !== 0) begin
      nfail++; $display("FAIL tx_handshake: got %0d violations required 0", viol);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_obs();
    rd_delay = 3;
    send_frame('{8'h52, 8'h44});
    while (tx_q.size() < 1 && k < 200) begin @(negedge core_clk); k++; end
    core_rst = 1'b1;
    repeat (2) @(negedge core_clk);
    core_rst = 1'b0;
    err_exp = 0;
    repeat (30) @(negedge core_clk);
    nvec++;
    if (tx_q.size() !== 1) begin
      nfail++; $display("FAIL reset_mid_tx: got %0d bytes required 1", tx_q.size());
    end
    nvec++;
    if ({tx_data, tx_valid, reg_addr, reg_wdata, reg_wr, reg_rd} !== 50'd0 || debug_bus_c !== 32'd0) begin
      nfail++; $display("FAIL reset_mid_outputs: got %h dbg %h required 0",
                        {tx_data, tx_valid, reg_addr, reg_wdata, reg_wr, reg_rd}, debug_bus_c);
    end
  endtask

  task automatic test_after_reset();
    clear_obs();
    rd_delay = 2;
    send_frame('{8'h57, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04});
    wait_tx(1);
    send_frame('{8'h52, 8'h5A});
    wait_tx(5);
    nvec++;
    if (tx_q !== '{8'h4B, 8'h01, 8'h02, 8'h03, 8'h04} || wr_q.size() !== 1 || wr_q[0] !== 40'h5A01020304) begin
      nfail++; $display("FAIL after_reset: got %p, %0d writes required 4b 01 02 03 04, 1 write", tx_q, wr_q.size());
    end
  endtask

  initial begin
    core_rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; rx_overflow = 1'b0; rx_parity_error = 1'b0;
    test_reset();
    test_bad_opcode();
    err_exp = 1;
    test_write();
    test_read();
    test_parity();
    test_rx_timeout();
    test_rd_timeout();
    test_drop_in_send();
    test_random();
    test_reset_mid();
    test_after_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
